// File: rtl/sonar_ranger.sv
// -----------------------------------------------------------------------------
// sonar_ranger
// Drives an ultrasonic ranging module. It fires a trigger pulse at a fixed
// repetition period and times the returned echo pulse. The echo-high time is
// converted to whole centimetres.
//
// Ports:
//   clk        in   single clock; all logic runs on the rising edge
//   rst_n      in   synchronous, active-low reset
//   echo       in   asynchronous echo input from the ultrasonic module
//   trig       out  trigger pulse to the ultrasonic module
//   disten     out  last range in cm (20'hFFFFF = no echo / out of range)
//   dist_valid out  one-cycle pulse when disten updates
//   timeout    out  one-cycle pulse, coincident with dist_valid, on timeout
//
// Optional feature macro: SONAR_MEDIAN_EN
//   When this macro is defined, every raw result enters a 3-entry history.
//   disten then shows the median of that history, and dist_valid/timeout
//   arrive one cycle later than they do in the default build.
//
// Parameter legality is the integrator's responsibility:
//   TRIG_CYCLES + 2*TIMEOUT_CYCLES + 4 < PERIOD_CYCLES, CYC_PER_CM >= 1,
//   TIMEOUT_CYCLES >= 2.
// -----------------------------------------------------------------------------
module sonar_ranger #(
    parameter int TRIG_CYCLES    = 500,
    parameter int PERIOD_CYCLES  = 3_000_000,
    parameter int TIMEOUT_CYCLES = 1_250_000,
    parameter int CYC_PER_CM     = 2900
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        echo,
    output logic        trig,
    output logic [19:0] disten,
    output logic        dist_valid,
    output logic        timeout
);

    localparam logic [31:0] TRIG_LAST    = 32'(TRIG_CYCLES - 1);
    localparam logic [31:0] PERIOD_LAST  = 32'(PERIOD_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] CM_LAST      = 32'(CYC_PER_CM - 1);
    localparam logic [19:0] DIST_MAX     = 20'hFFFFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRIG    = 3'd1,
        WAIT_HI = 3'd2,
        MEASURE = 3'd3,
        GAP     = 3'd4
    } state_t;

    state_t      state_r;
    logic        echo_meta_r;
    logic        echo_s;
    logic        echo_prev_r;
    logic [31:0] trig_cnt_r;
    logic [31:0] period_cnt_r;
    logic [31:0] tmo_cnt_r;     // cycles waited in WAIT_HI / echo-high cycles in MEASURE
    logic [31:0] sub_cnt_r;
    logic [19:0] cm_cnt_r;

    logic        echo_rise_s;
    logic [31:0] sub_step_s;
    logic [19:0] cm_step_s;
    logic        upd_s;
    logic        upd_to_s;
    logic [19:0] upd_dist_s;

`ifdef SONAR_MEDIAN_EN
    logic [19:0] hist0_r;
    logic [19:0] hist1_r;
    logic [19:0] hist2_r;
    logic        med_pend_r;
    logic        med_to_r;

    // Returns the middle value of three unsigned distances.
    function automatic logic [19:0] median3(input logic [19:0] a,
                                            input logic [19:0] b,
                                            input logic [19:0] c);
        logic [19:0] m;
        if (((a >= b) && (a <= c)) || ((a <= b) && (a >= c))) begin
            m = a;
        end else if (((b >= a) && (b <= c)) || ((b <= a) && (b >= c))) begin
            m = b;
        end else begin
            m = c;
        end
        return m;
    endfunction
`endif

    assign echo_rise_s = echo_s & ~echo_prev_r;

    // Counter values after one more echo-high cycle (the cm count saturates).
    always_comb begin
        sub_step_s = sub_cnt_r;
        cm_step_s  = cm_cnt_r;
        if (sub_cnt_r == CM_LAST) begin
            sub_step_s = 32'd0;
            if (cm_cnt_r == DIST_MAX) begin
                cm_step_s = cm_cnt_r;
            end else begin
                cm_step_s = cm_cnt_r + 20'd1;
            end
        end else begin
            sub_step_s = sub_cnt_r + 32'd1;
            cm_step_s  = cm_cnt_r;
        end
    end

    // Decide whether this cycle ends the measurement with a new result.
    always_comb begin
        upd_s      = 1'b0;
        upd_to_s   = 1'b0;
        upd_dist_s = cm_cnt_r;
        case (state_r)
            WAIT_HI: begin
                if (!echo_rise_s && (tmo_cnt_r == TIMEOUT_LAST)) begin
                    upd_s      = 1'b1;
                    upd_to_s   = 1'b1;
                    upd_dist_s = DIST_MAX;
                end else begin
                    upd_s = 1'b0;
                end
            end
            MEASURE: begin
                if (echo_s) begin
                    // This cycle would be echo-high cycle number TIMEOUT_CYCLES.
                    if (tmo_cnt_r == TIMEOUT_LAST) begin
                        upd_s      = 1'b1;
                        upd_to_s   = 1'b1;
                        upd_dist_s = DIST_MAX;
                    end else begin
                        upd_s = 1'b0;
                    end
                end else begin
                    // MEASURE is only entered with echo_s high, so low here is the falling edge.
                    upd_s      = 1'b1;
                    upd_dist_s = cm_cnt_r;
                end
            end
            default: begin
                upd_s = 1'b0;
            end
        endcase
    end

    // Echo synchronizer, ranging FSM, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            echo_meta_r  <= 1'b0;
            echo_s       <= 1'b0;
            echo_prev_r  <= 1'b0;
            trig_cnt_r   <= 32'd0;
            period_cnt_r <= 32'd0;
            tmo_cnt_r    <= 32'd0;
            sub_cnt_r    <= 32'd0;
            cm_cnt_r     <= 20'd0;
            trig         <= 1'b0;
            disten       <= 20'd0;
            dist_valid   <= 1'b0;
            timeout      <= 1'b0;
`ifdef SONAR_MEDIAN_EN
            hist0_r      <= 20'd0;
            hist1_r      <= 20'd0;
            hist2_r      <= 20'd0;
            med_pend_r   <= 1'b0;
            med_to_r     <= 1'b0;
`endif
        end else begin
            echo_meta_r <= echo;
            echo_s      <= echo_meta_r;
            echo_prev_r <= echo_s;

            case (state_r)
                IDLE: begin
                    state_r      <= TRIG;
                    trig         <= 1'b1;
                    trig_cnt_r   <= 32'd0;
                    period_cnt_r <= 32'd0;
                end
                TRIG: begin
                    period_cnt_r <= period_cnt_r + 32'd1;
                    if (trig_cnt_r == TRIG_LAST) begin
                        state_r   <= WAIT_HI;
                        trig      <= 1'b0;
                        tmo_cnt_r <= 32'd0;
                        sub_cnt_r <= 32'd0;
                        cm_cnt_r  <= 20'd0;
                    end else begin
                        trig_cnt_r <= trig_cnt_r + 32'd1;
                    end
                end
                WAIT_HI: begin
                    period_cnt_r <= period_cnt_r + 32'd1;
                    if (echo_rise_s) begin
                        // The rising cycle is itself the first echo-high cycle.
                        state_r   <= MEASURE;
                        tmo_cnt_r <= 32'd1;
                        sub_cnt_r <= sub_step_s;
                        cm_cnt_r  <= cm_step_s;
                    end else if (upd_s) begin
                        state_r <= GAP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 32'd1;
                    end
                end
                MEASURE: begin
                    period_cnt_r <= period_cnt_r + 32'd1;
                    if (upd_s) begin
                        state_r <= GAP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 32'd1;
                        sub_cnt_r <= sub_step_s;
                        cm_cnt_r  <= cm_step_s;
                    end
                end
                GAP: begin
                    if (period_cnt_r == PERIOD_LAST) begin
                        state_r      <= TRIG;
                        trig         <= 1'b1;
                        trig_cnt_r   <= 32'd0;
                        period_cnt_r <= 32'd0;
                    end else begin
                        period_cnt_r <= period_cnt_r + 32'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    trig    <= 1'b0;
                end
            endcase

`ifdef SONAR_MEDIAN_EN
            med_pend_r <= upd_s;
            med_to_r   <= upd_to_s;
            if (upd_s) begin
                hist2_r <= hist1_r;
                hist1_r <= hist0_r;
                hist0_r <= upd_dist_s;
            end else begin
                hist0_r <= hist0_r;
            end
            dist_valid <= med_pend_r;
            timeout    <= med_to_r;
            if (med_pend_r) begin
                disten <= median3(hist0_r, hist1_r, hist2_r);
            end else begin
                disten <= disten;
            end
`else
            dist_valid <= upd_s;
            timeout    <= upd_to_s;
            if (upd_s) begin
                disten <= upd_dist_s;
            end else begin
                disten <= disten;
            end
`endif
        end
    end

endmodule

// File: doc/sonar_ranger.md
SONAR_RANGER -- requirements
Module: sonar_ranger

Interface
REQ-001 Parameter TRIG_CYCLES, default 500, trigger pulse width in clk cycles (10 us at 50 MHz).
REQ-002 Parameter PERIOD_CYCLES, default 3_000_000, cycles from one trigger rise to the next (60 ms).
REQ-003 Parameter TIMEOUT_CYCLES, default 1_250_000, max cycles for echo wait and for echo high time, each.
REQ-004 Parameter CYC_PER_CM, default 2900, echo-high cycles per 1 cm of range.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 echo  in  1  asynchronous echo from ultrasonic module.
REQ-008 trig  out  1  trigger pulse to ultrasonic module.
REQ-009 disten  out  20  last range in cm; feeds the motor-drive stage's distance input.
REQ-010 dist_valid  out  1  one-cycle pulse when disten updates.
REQ-011 timeout  out  1  one-cycle pulse, coincident with dist_valid, when the update is a timeout.

Function
REQ-012 echo SHALL pass through a 2-flop synchronizer; echo_s is the second flop; all echo decisions use echo_s and its registered previous value.
REQ-013 FSM states SHALL be IDLE, TRIG, WAIT_HI, MEASURE, GAP.
REQ-014 IDLE -> TRIG on the first cycle after reset release.
REQ-015 TRIG: trig=1 for exactly TRIG_CYCLES cycles, then WAIT_HI; trig SHALL be 0 in all other states.
REQ-016 A period counter SHALL restart at 0 on entering TRIG; GAP -> TRIG when it reaches PERIOD_CYCLES-1.
REQ-017 WAIT_HI -> MEASURE on an echo_s rising edge (prev 0, now 1); an echo_s already high on entry SHALL NOT count as a rise.
REQ-018 WAIT_HI: if TIMEOUT_CYCLES elapse without a rise -> timeout update (REQ-022), then GAP.
REQ-019 MEASURE: a sub-counter counts echo_s-high cycles, wraps at CYC_PER_CM-1 and increments a cm counter on wrap; cm counter saturates at 20'hFFFFF.
REQ-020 Result SHALL be floor(N/CYC_PER_CM), N = number of echo_s-high cycles.
REQ-021 On echo_s falling edge in MEASURE: disten <= cm count, dist_valid=1 for one cycle on the next clk, timeout=0, then GAP.
REQ-022 Echo high for TIMEOUT_CYCLES in MEASURE, or timeout per REQ-018: disten <= 20'hFFFFF, dist_valid=1 and timeout=1 for one cycle, then GAP.
REQ-023 Echo edges in GAP, TRIG or IDLE SHALL be ignored; disten holds between updates.
REQ-024 Parameter legality: TRIG_CYCLES + 2*TIMEOUT_CYCLES + 4 < PERIOD_CYCLES; CYC_PER_CM >= 1.

Reset
REQ-025 rst_n=0 at a clk edge SHALL force state IDLE, trig=0, disten=0, dist_valid=0, timeout=0, all counters and synchronizer flops 0, regardless of state (incl. mid-TRIG, mid-MEASURE).
REQ-026 disten=0 after reset SHALL keep the downstream motor stage stopped until the first valid measurement.

Configuration
REQ-027 Macro SONAR_MEDIAN_EN defined: each new raw result (incl. 20'hFFFFF) SHALL enter a 3-entry history (reset 0); disten SHALL be the median of the 3 entries; dist_valid/timeout are delayed one extra cycle.
REQ-028 SONAR_MEDIAN_EN undefined: no history; disten = raw result per REQ-021/REQ-022.

Verification (TRIG_CYCLES=10, PERIOD_CYCLES=2000, TIMEOUT_CYCLES=400, CYC_PER_CM=4, macro undefined unless stated)
REQ-029 Reset release -> trig high exactly 10 cycles, next trig rise exactly 2000 cycles later; disten=0 throughout with echo held low.
REQ-030 echo high 40 cycles, 20 cycles after trig fall -> one dist_valid, disten=10, timeout=0; echo high 43 cycles -> disten=10.
REQ-031 echo never rises -> dist_valid and timeout pulse together 400 cycles after WAIT_HI entry, disten=20'hFFFFF; echo stuck high -> same result.
REQ-032 rst_n low for 1 cycle mid-MEASURE -> all outputs 0 next cycle, new trig starts after release, no stale dist_valid.
REQ-033 SONAR_MEDIAN_EN defined, raw results 10, 50, 12 -> disten sequence 0, 10, 12.
